// File: rtl/echo_delay_ctrl.sv
// -----------------------------------------------------------------------------
// echo_delay_ctrl
//
// Sequencer for the echo delay-line FIFO. The ADC data_valid strobe is
// synchronised into one-cycle sample ticks. On each tick the controller issues
// FIFO write and/or read requests so that the FIFO settles at exactly the
// selected delay (delay_sel * STEP samples). It fills, holds, shrinks (drains)
// and flushes the delay line. echo_en marks cycles where the FIFO output is a
// valid delayed sample.
//
// Ports:
//   sysclk      in   system clock, all logic on the rising edge
//   reset_n     in   asynchronous active-low reset
//   enable      in   echo function enable (level)
//   data_valid  in   ADC sample strobe, asynchronous, high >= 2 sysclk cycles
//   delay_sel   in   delay select, target = delay_sel * STEP samples
//   flush       in   one-cycle request to empty the delay line
//   fifo_full   in   FIFO full flag
//   fifo_empty  in   FIFO empty flag
//   wrreq       out  FIFO write request (registered, one cycle)
//   rdreq       out  FIFO read request (registered, one cycle)
//   sample_tick out  one-cycle pulse per accepted ADC sample
//   echo_en     out  FIFO q holds a valid delayed sample
//   occupancy   out  controller's count of words in the FIFO
//   busy        out  high while flushing or draining
// -----------------------------------------------------------------------------
module echo_delay_ctrl #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int STEP  = 64
) (
  input  logic          sysclk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          data_valid,
  input  logic [3:0]    delay_sel,
  input  logic          flush,
  input  logic          fifo_full,
  input  logic          fifo_empty,
  output logic          wrreq,
  output logic          rdreq,
  output logic          sample_tick,
  output logic          echo_en,
  output logic [AW:0]   occupancy,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN,
    S_FLUSH
  } state_t;

  localparam logic [AW+4:0] STEP_W  = (AW+5)'(STEP);
  localparam logic [AW+4:0] TGT_MAX = (AW+5)'(DEPTH - 1);
  localparam logic [AW:0]   TGT_CAP = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   OCC_MAX = (AW+1)'(DEPTH);

  // Synchroniser chain for the asynchronous data_valid strobe
  logic sync1_q, sync2_q, sync3_q;
  logic tick;

  state_t      state_q, state_d;
  logic [AW:0] occ_q, occ_d;
  logic [AW:0] tgt_q, tgt_d;
  logic        wrreq_q, wrreq_d;
  logic        rdreq_q, rdreq_d;
  logic        sample_tick_q;

  logic [AW+4:0] tgt_raw;
  logic [AW:0]   tgt_now;
  logic [AW:0]   occ_inc, occ_dec;
  logic          active;
  logic          flush_entry;

  // Rising edge of the synchronised strobe; one tick per data_valid pulse
  assign tick = sync2_q & ~sync3_q;

  // Target in samples, clamped to one less than the FIFO capacity
  assign tgt_raw = {{(AW+1){1'b0}}, delay_sel} * STEP_W;
  assign tgt_now = (tgt_raw > TGT_MAX) ? TGT_CAP : tgt_raw[AW:0];

  assign occ_inc = occ_q + 1'b1;
  assign occ_dec = occ_q - 1'b1;

  assign active = (state_q == S_FILL) || (state_q == S_RUN) || (state_q == S_DRAIN);

  // Flush/disable requests outrank ticks; a zero target only becomes visible
  // on a tick because the target is sampled only then.
  assign flush_entry = active && (flush || !enable || (tick && (tgt_now == '0)));

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    tgt_d   = tick ? tgt_now : tgt_q;
    wrreq_d = 1'b0;
    rdreq_d = 1'b0;

    if (state_q == S_FLUSH) begin
      // Free-running reads, not tick-gated, until the line is empty
      if ((occ_q == '0) || fifo_empty) begin
        occ_d   = '0;
        state_d = (enable && (tgt_q != '0)) ? S_FILL : S_IDLE;
      end else begin
        rdreq_d = 1'b1;
        occ_d   = occ_dec;
      end
    end else if (flush_entry) begin
      // Any coincident tick is dropped here
      state_d = S_FLUSH;
    end else if (tick && (active || (enable && (tgt_now != '0)))) begin
      // One tick handler for every working phase: the relation between the
      // freshly sampled target and the current occupancy decides whether the
      // tick grows, holds or shrinks the delay line.
      if (tgt_now > occ_q) begin
        if (fifo_full || (occ_q >= OCC_MAX)) begin
          // FIFO cannot take more: clamp the delay at the current depth
          state_d = S_RUN;
        end else begin
          wrreq_d = 1'b1;
          occ_d   = occ_inc;
          state_d = (occ_inc == tgt_now) ? S_RUN : S_FILL;
        end
      end else if (tgt_now < occ_q) begin
        rdreq_d = 1'b1;
        occ_d   = occ_dec;
        state_d = (occ_dec == tgt_now) ? S_RUN : S_DRAIN;
      end else begin
        state_d = S_RUN;
        // With the FIFO reporting full, skip the whole read/write pair so the
        // internal count stays in step with the FIFO.
        if (!fifo_full) begin
          wrreq_d = 1'b1;
          rdreq_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync3_q       <= 1'b0;
      sample_tick_q <= 1'b0;
      state_q       <= S_IDLE;
      occ_q         <= '0;
      tgt_q         <= '0;
      wrreq_q       <= 1'b0;
      rdreq_q       <= 1'b0;
    end else begin
      sync1_q       <= data_valid;
      sync2_q       <= sync1_q;
      sync3_q       <= sync2_q;
      sample_tick_q <= tick;
      state_q       <= state_d;
      occ_q         <= occ_d;
      tgt_q         <= tgt_d;
      wrreq_q       <= wrreq_d;
      rdreq_q       <= rdreq_d;
    end
  end

  assign wrreq       = wrreq_q;
  assign rdreq       = rdreq_q;
  assign sample_tick = sample_tick_q;
  assign occupancy   = occ_q;
  assign echo_en     = (state_q == S_RUN);
  assign busy        = (state_q == S_FLUSH) || (state_q == S_DRAIN);

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// -----------------------------------------------------------------------------
// tb_echo_delay_ctrl
//
// Directed sequence following the delay-line life cycle (fill, shrink, flush,
// flush/tick collision, asynchronous reset, full clamp) followed by a random
// mix of samples, delay changes, enable toggles and flushes. Every sample tick
// is compared against a transaction-level model of the delay line.
// -----------------------------------------------------------------------------
module tb_echo_delay_ctrl;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int STEP  = 64;

  // Model phases
  localparam int P_IDLE  = 0;
  localparam int P_FILL  = 1;
  localparam int P_RUN   = 2;
  localparam int P_DRAIN = 3;
  localparam int P_FLUSH = 4;

  logic          sysclk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          data_valid;
  logic [3:0]    delay_sel;
  logic          flush;
  logic          fifo_full;
  logic          fifo_empty;
  logic          wrreq;
  logic          rdreq;
  logic          sample_tick;
  logic          echo_en;
  logic [AW:0]   occupancy;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_samples = 0;

  int m_phase = P_IDLE;
  int m_occ   = 0;
  int m_tgt   = 0;

  echo_delay_ctrl #(.DEPTH(DEPTH), .AW(AW), .STEP(STEP)) dut (
    .sysclk      (sysclk),
    .reset_n     (reset_n),
    .enable      (enable),
    .data_valid  (data_valid),
    .delay_sel   (delay_sel),
    .flush       (flush),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .wrreq       (wrreq),
    .rdreq       (rdreq),
    .sample_tick (sample_tick),
    .echo_en     (echo_en),
    .occupancy   (occupancy),
    .busy        (busy)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int target_of(input int sel);
    int t;
    t = sel * STEP;
    if (t > DEPTH - 1) t = DEPTH - 1;
    return t;
  endfunction

  // Transaction-level view of one sample tick: what requests the tick should
  // produce and how the delay line length moves.
  task automatic model_tick(input int sel, input bit en, input bit full,
                            output bit wr, output bit rd, output bit to_flush);
    int tgt;
    tgt = target_of(sel);
    wr = 1'b0;
    rd = 1'b0;
    to_flush = 1'b0;
    m_tgt = tgt;
    if (m_phase == P_FLUSH) return;
    if (m_phase == P_IDLE && !(en && tgt > 0)) return;
    if (m_phase != P_IDLE && tgt == 0) begin
      to_flush = 1'b1;
      m_phase  = P_FLUSH;
      return;
    end
    if (tgt > m_occ) begin
      if (full) begin
        m_phase = P_RUN;
      end else begin
        wr = 1'b1;
        m_occ++;
        m_phase = (m_occ == tgt) ? P_RUN : P_FILL;
      end
    end else if (tgt < m_occ) begin
      rd = 1'b1;
      m_occ--;
      m_phase = (m_occ == tgt) ? P_RUN : P_DRAIN;
    end else begin
      m_phase = P_RUN;
      if (!full) begin
        wr = 1'b1;
        rd = 1'b1;
      end
    end
  endtask

  // Watch a flush run to completion and count the reads it issues.
  task automatic run_flush_reads(input int exp_reads, input int empty_after);
    int cnt;
    bit done;
    cnt  = 0;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge sysclk);
      #1;
      if (rdreq) cnt++;
      if (empty_after > 0 && cnt == empty_after) fifo_empty = 1'b1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    fifo_empty = 1'b0;
    check("flush_done", done, 1);
    check("flush_reads", cnt, exp_reads);
    check("flush_occ", occupancy, 0);
    check("flush_echo", echo_en, 0);
    m_occ   = 0;
    m_phase = (enable && m_tgt > 0) ? P_FILL : P_IDLE;
    $display("flush: reads=%0d occ=%0d en=%0b", cnt, occupancy, enable);
  endtask

  task automatic send_sample();
    bit wr, rd, tf;
    bit found;
    found = 1'b0;
    @(negedge sysclk);
    data_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge sysclk);
      #1;
      if (sample_tick) begin
        found = 1'b1;
        break;
      end
    end
    data_valid = 1'b0;
    n_samples++;
    check("tick_seen", found, 1);
    model_tick(int'(delay_sel), enable, fifo_full, wr, rd, tf);
    check("wrreq", wrreq, wr);
    check("rdreq", rdreq, rd);
    check("occupancy", occupancy, m_occ);
    check("echo_en", echo_en, (m_phase == P_RUN));
    check("busy", busy, (m_phase == P_DRAIN || m_phase == P_FLUSH));
    $display("sample %0d: sel=%0d en=%0b full=%0b wr=%0b rd=%0b occ=%0d echo=%0b busy=%0b",
             n_samples, delay_sel, enable, fifo_full, wrreq, rdreq, occupancy, echo_en, busy);
    if (tf) run_flush_reads(m_occ, 0);
    repeat (3) @(negedge sysclk);
  endtask

  task automatic enter_flush(input bit by_enable, input int empty_after);
    int exp_reads;
    @(negedge sysclk);
    if (by_enable) enable = 1'b0;
    else flush = 1'b1;
    @(posedge sysclk);
    #1;
    flush = 1'b0;
    check("flush_entry_busy", busy, 1);
    check("flush_entry_wr", wrreq, 0);
    check("flush_entry_rd", rdreq, 0);
    m_phase = P_FLUSH;
    exp_reads = (empty_after > 0 && empty_after < m_occ) ? empty_after : m_occ;
    run_flush_reads(exp_reads, empty_after);
  endtask

  initial begin
    int pulses;
    int pulse_idx;
    int r;

    reset_n    = 1'b0;
    enable     = 1'b0;
    data_valid = 1'b0;
    delay_sel  = 4'd0;
    flush      = 1'b0;
    fifo_full  = 1'b0;
    fifo_empty = 1'b0;

    // Reset state
    repeat (3) @(posedge sysclk);
    #1;
    check("rst_wrreq", wrreq, 0);
    check("rst_rdreq", rdreq, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_echo", echo_en, 0);
    check("rst_busy", busy, 0);
    check("rst_occ", occupancy, 0);
    @(negedge sysclk);
    reset_n = 1'b1;
    repeat (2) @(negedge sysclk);

    // Tick timing: level held 5 cycles gives one pulse on the third edge,
    // counting the edge that first samples data_valid high
    pulses    = 0;
    pulse_idx = -1;
    @(negedge sysclk);
    data_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge sysclk);
      #1;
      if (i == 5) data_valid = 1'b0;
      if (sample_tick) begin
        pulses++;
        pulse_idx = i;
      end
    end
    check("tick_pulses", pulses, 1);
    check("tick_edge", pulse_idx, 2);
    check("tick_idle_wr", wrreq, 0);
    $display("tick timing: pulses=%0d edge=%0d", pulses, pulse_idx);
    m_tgt = 0;
    repeat (3) @(negedge sysclk);

    // Fill to 128 then two steady-state ticks
    enable    = 1'b1;
    delay_sel = 4'd2;
    for (int i = 0; i < 130; i++) send_sample();
    check("fill_occ", occupancy, 128);
    check("fill_echo", echo_en, 1);

    // Shrink to 64, then one steady tick
    delay_sel = 4'd1;
    for (int i = 0; i < 65; i++) send_sample();
    check("shrink_occ", occupancy, 64);

    // Flush from 64: 64 reads, back to FILL
    enter_flush(1'b0, 0);
    for (int i = 0; i < 64; i++) send_sample();

    // Flush coinciding with a tick: tick dropped, no write
    @(negedge sysclk);
    data_valid = 1'b1;
    @(posedge sysclk);
    @(posedge sysclk);
    @(negedge sysclk);
    flush = 1'b1;
    @(posedge sysclk);
    #1;
    flush      = 1'b0;
    data_valid = 1'b0;
    check("coll_tick", sample_tick, 1);
    check("coll_wr", wrreq, 0);
    check("coll_rd", rdreq, 0);
    check("coll_busy", busy, 1);
    check("coll_occ", occupancy, 64);
    $display("collision: tick=%0b wr=%0b busy=%0b occ=%0d", sample_tick, wrreq, busy, occupancy);
    m_tgt   = target_of(int'(delay_sel));
    m_phase = P_FLUSH;
    run_flush_reads(20, 20);
    repeat (3) @(negedge sysclk);

    // Asynchronous reset in the middle of a fill
    delay_sel = 4'd2;
    for (int i = 0; i < 37; i++) send_sample();
    check("pre_reset_occ", occupancy, 37);
    @(negedge sysclk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_wrreq", wrreq, 0);
    check("arst_rdreq", rdreq, 0);
    check("arst_tick", sample_tick, 0);
    check("arst_echo", echo_en, 0);
    check("arst_busy", busy, 0);
    check("arst_occ", occupancy, 0);
    $display("async reset: occ=%0d echo=%0b", occupancy, echo_en);
    m_occ   = 0;
    m_phase = P_IDLE;
    m_tgt   = 0;
    @(negedge sysclk);
    reset_n = 1'b1;
    repeat (2) @(negedge sysclk);

    // Refill to 100, then clamp on fifo_full
    for (int i = 0; i < 100; i++) send_sample();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) send_sample();
    check("clamp_occ", occupancy, 100);
    check("clamp_echo", echo_en, 1);
    fifo_full = 1'b0;
    send_sample();

    // Random mix
    for (int it = 0; it < 150; it++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        if (m_phase == P_FILL || m_phase == P_RUN || m_phase == P_DRAIN)
          enter_flush(1'b0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
      end else if (r == 1) begin
        if (enable) begin
          if (m_phase == P_FILL || m_phase == P_RUN || m_phase == P_DRAIN) begin
            enter_flush(1'b1, 0);
          end else begin
            @(negedge sysclk);
            enable = 1'b0;
          end
        end else begin
          @(negedge sysclk);
          enable = 1'b1;
        end
      end else if (r <= 4) begin
        @(negedge sysclk);
        delay_sel = 4'($urandom_range(0, 3));
      end else begin
        send_sample();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
